// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - circular free list of physical register tags with one-cycle flush recovery
module phys_free_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_W    = 6,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [ALLOC_W-1:0]                          alloc_req,
    output logic                                        alloc_ready,
    output logic [ALLOC_W-1:0][PHYS_W-1:0]              alloc_phys,
    input  logic [FREE_W-1:0]                           free_en,
    input  logic [FREE_W-1:0][PHYS_W-1:0]               free_phys,
    input  logic                                        flush,
    output logic [$clog2(PHYS_REGS-ARCH_REGS):0]        free_count,
    output logic                                        overflow_err
);
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PHYS_W-1:0] mem_q [DEPTH];
    logic [PHYS_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  spec_head_q, spec_head_d;
    logic [PTR_W-1:0]  commit_head_q, commit_head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              overflow_err_q, overflow_err_d;
    logic [PTR_W-1:0]  alloc_cnt, free_cnt, rd_ptr, wr_ptr;
    logic              full;

    assign free_count   = tail_q - spec_head_q;
    assign overflow_err = overflow_err_q;
    // Every free tag is already in the queue, so a further release has nowhere legal to go.
    assign full         = (free_count == PTR_W'(DEPTH));

    always_comb begin
        alloc_cnt = '0;
        rd_ptr    = spec_head_q;
        for (int k = 0; k < ALLOC_W; k++) begin
            alloc_phys[k] = mem_q[spec_head_q[IDX_W-1:0]];
            if (alloc_req[k]) begin
                rd_ptr        = spec_head_q + alloc_cnt;
                alloc_phys[k] = mem_q[rd_ptr[IDX_W-1:0]];
                alloc_cnt     = alloc_cnt + PTR_W'(1);
            end
        end
        alloc_ready = !flush && (free_count >= alloc_cnt);
    end

    always_comb begin
        mem_d          = mem_q;
        free_cnt       = '0;
        wr_ptr         = tail_q;
        overflow_err_d = overflow_err_q | (full & (|free_en));
        if (!full) begin
            for (int k = 0; k < FREE_W; k++) begin
                if (free_en[k]) begin
                    wr_ptr                     = tail_q + free_cnt;
                    mem_d[wr_ptr[IDX_W-1:0]]   = free_phys[k];
                    free_cnt                   = free_cnt + PTR_W'(1);
                end
            end
        end
        tail_d        = tail_q + free_cnt;
        commit_head_d = commit_head_q + free_cnt;
        // Squashed allocations sit between the committed and speculative heads; rewinding reclaims them.
        if (flush) begin
            spec_head_d = commit_head_d;
        end else if (alloc_ready) begin
            spec_head_d = spec_head_q + alloc_cnt;
        end else begin
            spec_head_d = spec_head_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PHYS_W'(ARCH_REGS + i);
            end
            spec_head_q    <= '0;
            commit_head_q  <= '0;
            tail_q         <= PTR_W'(DEPTH);
            overflow_err_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            spec_head_q    <= spec_head_d;
            commit_head_q  <= commit_head_d;
            tail_q         <= tail_d;
            overflow_err_q <= overflow_err_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - self-checking bench for phys_free_list against a queue-based model
module tb_phys_free_list;
    localparam int DEPTH  = 32;
    localparam int PHYS_W = 6;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0]             alloc_req;
    logic                   alloc_ready;
    logic [1:0][PHYS_W-1:0] alloc_phys;
    logic [1:0]             free_en;
    logic [1:0][PHYS_W-1:0] free_phys;
    logic                   flush;
    logic [5:0]             free_count;
    logic                   overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: allocatable tags in order, and allocated-but-uncommitted tags in program order.
    int free_q[$];
    int busy_q[$];
    bit m_ovf;

    phys_free_list dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_phys   (alloc_phys),
        .free_en      (free_en),
        .free_phys    (free_phys),
        .flush        (flush),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic int pop2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        free_q.delete();
        busy_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(32 + i);
        m_ovf = 1'b0;
    endtask

    task automatic model_update();
        int na, nf;
        bit rdy;
        int freed[$];
        na  = pop2(alloc_req);
        nf  = pop2(free_en);
        rdy = !flush && (free_q.size() >= na);
        if (nf > 0 && free_q.size() == DEPTH) begin
            m_ovf = 1'b1;
            nf    = 0;
        end else begin
            for (int k = 0; k < 2; k++) if (free_en[k]) freed.push_back(int'(free_phys[k]));
        end
        repeat (nf) void'(busy_q.pop_front());
        if (flush) begin
            for (int i = busy_q.size() - 1; i >= 0; i--) free_q.push_front(busy_q[i]);
            busy_q.delete();
        end else if (rdy) begin
            repeat (na) busy_q.push_back(free_q.pop_front());
        end
        foreach (freed[i]) free_q.push_back(freed[i]);
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] fen,
                         input logic [5:0] p1, input logic [5:0] p0, input logic fl);
        alloc_req    = req;
        free_en      = fen;
        free_phys[1] = p1;
        free_phys[0] = p0;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (free_count !== 6'd32) begin n_errors++; $display("FAIL reset_free_count: got %0d want 32", free_count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (alloc_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
        n_checks++; if (alloc_phys[0] !== 6'd32) begin n_errors++; $display("FAIL reset_offer0: got %0d want 32", alloc_phys[0]); end
        n_checks++; if (alloc_phys[1] !== 6'd33) begin n_errors++; $display("FAIL reset_offer1: got %0d want 33", alloc_phys[1]); end
        tick();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd30) begin n_errors++; $display("FAIL pair_free_count: got %0d want 30", free_count); end
        n_checks++; if (alloc_phys[0] !== 6'd34) begin n_errors++; $display("FAIL pair_offer0: got %0d want 34", alloc_phys[0]); end
        n_checks++; if (alloc_phys[1] !== 6'd35) begin n_errors++; $display("FAIL pair_offer1: got %0d want 35", alloc_phys[1]); end
        tick();
    endtask

    task automatic test_single_slot();
        do_reset();
        drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (alloc_phys[1] !== 6'd32) begin n_errors++; $display("FAIL slot1_offer: got %0d want 32", alloc_phys[1]); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_errors++; $display("FAIL slot1_ready: got %b want 1", alloc_ready); end
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd31) begin n_errors++; $display("FAIL slot1_count: got %0d want 31", free_count); end
    endtask

    task automatic test_empty();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
            n_checks++; if (alloc_phys[0] !== 6'(32 + 2 * i)) begin n_errors++; $display("FAIL drain_offer: cycle %0d got %0d want %0d", i, alloc_phys[0], 32 + 2 * i); end
            tick();
        end
        drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd0) begin n_errors++; $display("FAIL empty_count: got %0d want 0", free_count); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_errors++; $display("FAIL empty_ready: got %b want 0", alloc_ready); end
        tick();
        drive(2'b00, 2'b01, 6'd0, 6'd5, 1'b0);
        n_checks++; if (free_count !== 6'd0) begin n_errors++; $display("FAIL stall_count: got %0d want 0", free_count); end
        tick();
        drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (alloc_ready !== 1'b1) begin n_errors++; $display("FAIL refill_ready: got %b want 1", alloc_ready); end
        n_checks++; if (alloc_phys[0] !== 6'd5) begin n_errors++; $display("FAIL refill_offer: got %0d want 5", alloc_phys[0]); end
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd0) begin n_errors++; $display("FAIL refill_count: got %0d want 0", free_count); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b00, 2'b11, 6'd2, 6'd1, 1'b0);
        n_checks++; if (free_count !== 6'd27) begin n_errors++; $display("FAIL alloc5_count: got %0d want 27", free_count); end
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
        n_checks++; if (free_count !== 6'd29) begin n_errors++; $display("FAIL free2_count: got %0d want 29", free_count); end
        tick();
        drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd32) begin n_errors++; $display("FAIL flush_count: got %0d want 32", free_count); end
        n_checks++; if (alloc_phys[0] !== 6'd34) begin n_errors++; $display("FAIL flush_offer: got %0d want 34", alloc_phys[0]); end
        tick();
    endtask

    task automatic test_flush_combo();
        do_reset();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b11, 2'b01, 6'd0, 6'd7, 1'b1);
        n_checks++; if (alloc_ready !== 1'b0) begin n_errors++; $display("FAIL combo_ready: got %b want 0", alloc_ready); end
        tick();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (free_count !== 6'd32) begin n_errors++; $display("FAIL combo_count: got %0d want 32", free_count); end
        n_checks++; if (alloc_phys[0] !== 6'd33) begin n_errors++; $display("FAIL combo_offer0: got %0d want 33", alloc_phys[0]); end
        n_checks++; if (alloc_phys[1] !== 6'd34) begin n_errors++; $display("FAIL combo_offer1: got %0d want 34", alloc_phys[1]); end
        tick();
    endtask

    task automatic test_wrap_random();
        logic [1:0] req, fen;
        logic fl;
        int r;
        logic [5:0] d_spec, d_tail;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 0) begin
                req = 2'b01; fen = 2'b00; fl = 1'b0;
            end else if (i <= 40) begin
                req = 2'b01; fen = 2'b01; fl = 1'b0;
            end else begin
                req = 2'($urandom_range(0, 3));
                fen = 2'($urandom_range(0, 3));
                fl  = ($urandom_range(0, 15) == 0);
            end
            if (pop2(fen) > busy_q.size()) fen = (busy_q.size() > 0) ? 2'b01 : 2'b00;
            drive(req, fen, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), fl);
            n_checks++; if (alloc_ready !== (!fl && free_q.size() >= pop2(req))) begin n_errors++; $display("FAIL rnd_ready: cycle %0d got %b req %b count %0d", i, alloc_ready, req, free_q.size()); end
            n_checks++; if (free_count !== 6'(free_q.size())) begin n_errors++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", i, free_count, free_q.size()); end
            n_checks++; if (overflow_err !== m_ovf) begin n_errors++; $display("FAIL rnd_overflow: cycle %0d got %b want %b", i, overflow_err, m_ovf); end
            r = 0;
            for (int k = 0; k < 2; k++) begin
                if (req[k]) begin
                    if (r < free_q.size()) begin
                        n_checks++; if (alloc_phys[k] !== 6'(free_q[r])) begin n_errors++; $display("FAIL rnd_offer: cycle %0d slot %0d got %0d want %0d", i, k, alloc_phys[k], free_q[r]); end
                    end
                    r++;
                end
            end
            d_spec = dut.spec_head_q - dut.commit_head_q;
            d_tail = dut.tail_q - dut.commit_head_q;
            n_checks++; if (!(d_spec <= d_tail)) begin n_errors++; $display("FAIL ptr_order: cycle %0d spec-commit %0d tail-commit %0d", i, d_spec, d_tail); end
            tick();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(2'b00, 2'b01, 6'd0, 6'd9, 1'b0);
        tick();
        drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
        n_checks++; if (free_count !== 6'd32) begin n_errors++; $display("FAIL ovf_count: got %0d want 32", free_count); end
        n_checks++; if (alloc_phys[0] !== 6'd32) begin n_errors++; $display("FAIL ovf_offer: got %0d want 32", alloc_phys[0]); end
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
        n_checks++; if (free_count !== 6'd31) begin n_errors++; $display("FAIL ovf_after_count: got %0d want 31", free_count); end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0); tick();
        drive(2'b11, 2'b01, 6'd0, 6'd3, 1'b0); tick();
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++; if (free_count !== 6'd32) begin n_errors++; $display("FAIL midrst_count: got %0d want 32", free_count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_errors++; $display("FAIL midrst_overflow: got %b want 0", overflow_err); end
        model_reset();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        n_checks++; if (alloc_phys[0] !== 6'd32) begin n_errors++; $display("FAIL midrst_offer0: got %0d want 32", alloc_phys[0]); end
        n_checks++; if (alloc_phys[1] !== 6'd33) begin n_errors++; $display("FAIL midrst_offer1: got %0d want 33", alloc_phys[1]); end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_slot();
        test_empty();
        test_flush();
        test_flush_combo();
        test_wrap_random();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
